// File: rtl/bin2seg_pkg.sv
// Shared types and constants for the iterative binary-to-7-segment converter.
package bin2seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ENCODE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low patterns for decimal digits 0..9, bit0 = segment a.
    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // BCD nibbles needed for a width-bit magnitude: ceil(width*log10(2)) + 1.
    // log10(2) is approximated as 0.30103 in fixed point.
    function automatic int nbcd(input int width);
        return (width * 30103 + 99999) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bin2seg_iter_if.sv
// Handshake and display bus of the binary-to-7-segment converter.
interface bin2seg_iter_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  blank_en;
    logic [7*DIGITS-1:0]   seg;
    logic [6:0]            sign_seg;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;
    logic                  out_valid;

    modport master (
        output in_valid, in_data, blank_en,
        input  in_ready, seg, sign_seg, bcd, ovf, out_valid
    );

    modport slave (
        input  in_valid, in_data, blank_en,
        output in_ready, seg, sign_seg, bcd, ovf, out_valid
    );

endinterface

// File: rtl/seg7_encode.sv
// Combinational decimal digit to active-low 7-segment pattern.
module seg7_encode
    import bin2seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Non-decimal nibbles never occur in a valid accumulator; show them as blank.
    always_comb begin
        seg = SEG_BLANK;
        if (digit <= 4'd9) seg = SEG_TABLE[digit];
    end

endmodule

// File: rtl/bin2seg_iter.sv
// Iterative double-dabble converter: one input bit per clock, then one cycle
// to encode the BCD accumulator into registered 7-segment/BCD outputs.
module bin2seg_iter
    import bin2seg_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    bin2seg_iter_if.slave bus
);

    localparam int NB   = nbcd(WIDTH);
    localparam int PADN = (NB > DIGITS) ? NB : DIGITS;
    localparam int CW   = $clog2(WIDTH + 1);

    state_t               state, state_next;
    logic [WIDTH-1:0]     mag;
    logic [4*NB-1:0]      acc;
    logic [4*NB-1:0]      acc_adj;
    logic [4*PADN-1:0]    acc_pad;
    logic [CW-1:0]        cnt;
    logic                 neg;
    logic                 blank;
    logic                 in_neg;
    logic [WIDTH-1:0]     in_mag;
    logic [4*DIGITS-1:0]  bcd_c;
    logic [7*DIGITS-1:0]  raw_seg;
    logic [7*DIGITS-1:0]  seg_c;
    logic                 ovf_c;
    logic                 seen;
    logic [7*DIGITS-1:0]  seg_q;
    logic [4*DIGITS-1:0]  bcd_q;
    logic [6:0]           sign_q;
    logic                 ovf_q;
    logic                 out_valid_q;

    // The most negative input negates to 2^(WIDTH-1), which still fits unsigned.
    assign in_neg = (SIGNED != 0) && bus.in_data[WIDTH-1];
    assign in_mag = in_neg ? (~bus.in_data + WIDTH'(1)) : bus.in_data;

    // Digits above the accumulator width read as zero.
    assign acc_pad = (4*PADN)'(acc);
    assign bcd_c   = acc_pad[4*DIGITS-1:0];

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next state: accept in IDLE, one shift per bit, one encode cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_next = ENCODE;
            ENCODE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would reach 10 or more after doubling.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < NB; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    // Conversion datapath: load on accept, shift the magnitude into the accumulator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mag   <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            blank <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mag   <= in_mag;
                        neg   <= in_neg;
                        blank <= bus.blank_en;
                        acc   <= '0;
                        cnt   <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    {acc, mag} <= {acc_adj, mag} << 1;
                    cnt        <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Overflow when any nibble beyond the displayed digits is nonzero.
    always_comb begin
        ovf_c = 1'b0;
        for (int i = DIGITS; i < PADN; i++) begin
            ovf_c = ovf_c | (acc_pad[4*i +: 4] != 4'd0);
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_enc
        seg7_encode u_enc (
            .digit (bcd_c[4*i +: 4]),
            .seg   (raw_seg[7*i +: 7])
        );
    end

    // Final digit patterns: dashes on overflow, otherwise leading-zero blanking from the top.
    always_comb begin
        seg_c = raw_seg;
        seen  = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (bcd_c[4*i +: 4] != 4'd0) seen = 1'b1;
            if (ovf_c)                               seg_c[7*i +: 7] = SEG_DASH;
            else if (blank && !seen && (i != 0))     seg_c[7*i +: 7] = SEG_BLANK;
        end
    end

    // Output registers: updated only in ENCODE, held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg_q       <= {DIGITS{SEG_TABLE[0]}};
            bcd_q       <= '0;
            sign_q      <= SEG_BLANK;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state == ENCODE);
            if (state == ENCODE) begin
                seg_q  <= seg_c;
                bcd_q  <= ovf_c ? {DIGITS{4'h9}} : bcd_c;
                ovf_q  <= ovf_c;
                sign_q <= neg ? SEG_DASH : SEG_BLANK;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.seg       = seg_q;
    assign bus.bcd       = bcd_q;
    assign bus.sign_seg  = sign_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;

endmodule
